// File: rtl/disp_pixout_pkg.sv
// Shared display-output definitions: FSM encoding, colour defaults and the
// panel-side pipeline latency.
package disp_pixout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int          COLW_DEF      = 8;
  localparam logic [23:0] BLANK_RGB_DEF = 24'h000000;
  localparam int          PIX_LAT       = 2;

  typedef struct packed {
    logic hsync_x;
    logic vsync_x;
    logic de;
  } sync_t;

  // Syncs idle high and DE idles low so the panel sees a quiet bus in reset.
  localparam sync_t SYNC_RST = '{hsync_x: 1'b1, vsync_x: 1'b1, de: 1'b0};

endpackage

// File: rtl/disp_pixout_sync_dly.sv
// N-stage delay line for the panel timing bundle {HSYNC_X, VSYNC_X, DE}.
module disp_pixout_sync_dly
  import disp_pixout_pkg::*;
#(
  parameter int N = PIX_LAT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  sync_t src,
  output sync_t dly
);

  sync_t pipe [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) pipe[i] <= SYNC_RST;
    end else begin
      pipe[0] <= src;
      for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dly = pipe[N-1];

endmodule

// File: rtl/disp_pixout.sv
// Panel output stage: aligns FIFO pixels with delayed syncgen timing, gates
// display on/off at frame starts and flags line-FIFO underflow.
module disp_pixout
  import disp_pixout_pkg::*;
#(
  parameter int              COLW      = COLW_DEF,
  parameter logic [3*COLW-1:0] BLANK_RGB = (3*COLW)'(BLANK_RGB_DEF)
) (
  input  logic              DCLK,
  input  logic              DRST_X,
  input  logic              DISPON,
  input  logic              CLR_UNDER,
  input  logic              SG_HSYNC_X,
  input  logic              SG_VSYNC_X,
  input  logic              SG_preDE,
  input  logic              SG_VRSTART,
  input  logic [3*COLW-1:0] FIFO_DOUT,
  input  logic              FIFO_EMPTY,
  output logic              FIFO_RD,
  output logic [COLW-1:0]   DSP_R,
  output logic [COLW-1:0]   DSP_G,
  output logic [COLW-1:0]   DSP_B,
  output logic              DSP_DE,
  output logic              DSP_HSYNC_X,
  output logic              DSP_VSYNC_X,
  output logic              UNDERFLOW,
  output logic              DISP_ACT
);

  state_t            state;
  logic              vr_d1;
  logic              vr_rise;
  logic              act;
  logic              rd_d1;
  logic              de_d1;
  logic [3*COLW-1:0] rgb;
  sync_t             sync_src;
  sync_t             sync_dly;

  assign vr_rise = SG_VRSTART & ~vr_d1;
  assign act     = (state == ACTIVE);
  assign FIFO_RD = SG_preDE & act & ~FIFO_EMPTY;

  // Display on/off only takes effect on a frame-start edge.
  always_ff @(posedge DCLK or negedge DRST_X) begin
    if (!DRST_X) begin
      state    <= IDLE;
      DISP_ACT <= 1'b0;
      vr_d1    <= 1'b0;
    end else begin
      vr_d1 <= SG_VRSTART;
      case (state)
        IDLE: begin
          if (DISPON) state <= WAIT;
        end
        WAIT: begin
          if (!DISPON) begin
            state <= IDLE;
          end else if (vr_rise) begin
            state    <= ACTIVE;
            DISP_ACT <= 1'b1;
          end
        end
        ACTIVE: begin
          if (vr_rise && !DISPON) begin
            state    <= IDLE;
            DISP_ACT <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          DISP_ACT <= 1'b0;
        end
      endcase
    end
  end

  // FIFO data lands one cycle after the pop, so the pixel register sits at
  // the second stage alongside the delayed DE.
  always_ff @(posedge DCLK or negedge DRST_X) begin
    if (!DRST_X) begin
      rd_d1     <= 1'b0;
      de_d1     <= 1'b0;
      rgb       <= '0;
      UNDERFLOW <= 1'b0;
    end else begin
      rd_d1 <= FIFO_RD;
      de_d1 <= SG_preDE;
      if (rd_d1)      rgb <= FIFO_DOUT;
      else if (de_d1) rgb <= BLANK_RGB;
      else            rgb <= '0;
      if (SG_preDE && act && FIFO_EMPTY) UNDERFLOW <= 1'b1;
      else if (CLR_UNDER)                UNDERFLOW <= 1'b0;
    end
  end

  assign sync_src = '{hsync_x: SG_HSYNC_X, vsync_x: SG_VSYNC_X, de: SG_preDE};

  disp_pixout_sync_dly #(.N(PIX_LAT)) u_sync_dly (
    .clk   (DCLK),
    .rst_n (DRST_X),
    .src   (sync_src),
    .dly   (sync_dly)
  );

  assign DSP_DE      = sync_dly.de;
  assign DSP_HSYNC_X = sync_dly.hsync_x;
  assign DSP_VSYNC_X = sync_dly.vsync_x;
  assign {DSP_R, DSP_G, DSP_B} = rgb;

endmodule

// File: tb/tb_disp_pixout.sv
// Bench for disp_pixout: FIFO model plus a 2-deep output scoreboard driven by
// a reference frame-gating model, and per-scenario directed checks.
module tb_disp_pixout;
  import disp_pixout_pkg::*;

  localparam logic [23:0] BLANK = 24'hA5C35A;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } exp_t;

  logic        DCLK = 0, DRST_X = 1, DISPON = 0, CLR_UNDER = 0;
  logic        SG_HSYNC_X = 1, SG_VSYNC_X = 1, SG_preDE = 0, SG_VRSTART = 0;
  logic        FIFO_EMPTY = 1;
  logic [23:0] FIFO_DOUT = '0;
  logic        FIFO_RD, DSP_DE, DSP_HSYNC_X, DSP_VSYNC_X, UNDERFLOW, DISP_ACT;
  logic [7:0]  DSP_R, DSP_G, DSP_B;

  int          n_chk = 0, n_fail = 0, rd_cnt = 0;
  logic        sb_on = 0, force_empty = 0, pop_req = 0, got_first = 0;
  logic [23:0] first_rgb = '0;
  exp_t        sb[$];
  logic [23:0] fifo_q[$];
  state_t      m_state = IDLE;
  logic        m_vr_d1 = 0, m_under = 0, m_act, m_pop, m_vr_edge;
  exp_t        e;

  disp_pixout #(.COLW(8), .BLANK_RGB(BLANK)) dut (
    .DCLK(DCLK), .DRST_X(DRST_X), .DISPON(DISPON), .CLR_UNDER(CLR_UNDER),
    .SG_HSYNC_X(SG_HSYNC_X), .SG_VSYNC_X(SG_VSYNC_X), .SG_preDE(SG_preDE),
    .SG_VRSTART(SG_VRSTART), .FIFO_DOUT(FIFO_DOUT), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RD(FIFO_RD), .DSP_R(DSP_R), .DSP_G(DSP_G), .DSP_B(DSP_B),
    .DSP_DE(DSP_DE), .DSP_HSYNC_X(DSP_HSYNC_X), .DSP_VSYNC_X(DSP_VSYNC_X),
    .UNDERFLOW(UNDERFLOW), .DISP_ACT(DISP_ACT)
  );

  always #5 DCLK = ~DCLK;

  // FIFO model: pops what the reference model says was read last cycle.
  initial forever begin
    @(posedge DCLK);
    #2;
    if (pop_req && fifo_q.size() > 0) FIFO_DOUT = fifo_q.pop_front();
    pop_req = 0;
    FIFO_EMPTY = force_empty || (fifo_q.size() == 0);
  end

  // Scoreboard: expectation pushed for the current inputs, popped PIX_LAT cycles later.
  initial forever begin
    @(negedge DCLK);
    if (sb_on) begin
      if (DSP_DE && !got_first) begin
        got_first = 1;
        first_rgb = {DSP_R, DSP_G, DSP_B};
      end
      e = sb.pop_front();
      n_chk++; if (DSP_DE !== e.de) begin n_fail++; $display("FAIL sb_de t=%0t got %b exp %b", $time, DSP_DE, e.de); end
      n_chk++; if (DSP_HSYNC_X !== e.hs) begin n_fail++; $display("FAIL sb_hsync t=%0t got %b exp %b", $time, DSP_HSYNC_X, e.hs); end
      n_chk++; if (DSP_VSYNC_X !== e.vs) begin n_fail++; $display("FAIL sb_vsync t=%0t got %b exp %b", $time, DSP_VSYNC_X, e.vs); end
      n_chk++; if ({DSP_R, DSP_G, DSP_B} !== e.rgb) begin n_fail++; $display("FAIL sb_rgb t=%0t got %h exp %h", $time, {DSP_R, DSP_G, DSP_B}, e.rgb); end
      m_act = (m_state == ACTIVE);
      m_pop = SG_preDE && m_act && !FIFO_EMPTY;
      n_chk++; if (FIFO_RD !== m_pop) begin n_fail++; $display("FAIL sb_fifo_rd t=%0t got %b exp %b", $time, FIFO_RD, m_pop); end
      n_chk++; if (DISP_ACT !== m_act) begin n_fail++; $display("FAIL sb_disp_act t=%0t got %b exp %b", $time, DISP_ACT, m_act); end
      n_chk++; if (UNDERFLOW !== m_under) begin n_fail++; $display("FAIL sb_underflow t=%0t got %b exp %b", $time, UNDERFLOW, m_under); end
      sb.push_back('{de: SG_preDE, hs: SG_HSYNC_X, vs: SG_VSYNC_X,
                     rgb: m_pop ? fifo_q[0] : (SG_preDE ? BLANK : 24'h0)});
      pop_req = m_pop;
      if (SG_preDE && m_act && FIFO_EMPTY) m_under = 1;
      else if (CLR_UNDER)                  m_under = 0;
      m_vr_edge = SG_VRSTART && !m_vr_d1;
      m_vr_d1   = SG_VRSTART;
      if (m_state == IDLE)      m_state = DISPON ? WAIT : IDLE;
      else if (m_state == WAIT) m_state = !DISPON ? IDLE : (m_vr_edge ? ACTIVE : WAIT);
      else if (m_vr_edge && !DISPON) m_state = IDLE;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic de, input logic hs, input logic vs, input logic vr,
                       input logic ef, input logic clr, input logic dis);
    @(posedge DCLK);
    #1;
    SG_preDE = de; SG_HSYNC_X = hs; SG_VSYNC_X = vs; SG_VRSTART = vr;
    force_empty = ef; CLR_UNDER = clr; DISPON = dis;
    #2;
    if (FIFO_RD) rd_cnt++;
  endtask

  // 16-cycle line: HSYNC low for 2, preDE for pixels at cycles 4..11.
  task automatic line(input logic vs, input logic vr, input logic don, input int doff_at,
                      input int ef_from, input int ef_n, input int clr_at);
    logic de, ef, dis;
    int   px;
    for (int c = 0; c < 16; c++) begin
      de  = (c >= 4 && c < 12);
      px  = c - 4;
      ef  = de && px >= ef_from && px < ef_from + ef_n;
      dis = (doff_at >= 0 && c >= doff_at) ? 1'b0 : don;
      drive(de, c >= 2, vs, vr, ef, c == clr_at, dis);
    end
  endtask

  task automatic do_reset();
    sb_on = 0; DRST_X = 0; DISPON = 0; CLR_UNDER = 0;
    SG_preDE = 0; SG_HSYNC_X = 1; SG_VSYNC_X = 1; SG_VRSTART = 0; force_empty = 0;
    pop_req = 0;
    repeat (3) @(posedge DCLK);
    #1;
    m_state = IDLE; m_vr_d1 = 0; m_under = 0;
    sb.delete();
    repeat (PIX_LAT) sb.push_back('{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 24'h0});
    DRST_X = 1; sb_on = 1;
  endtask

  task automatic test_reset();
    #1 DRST_X = 0;
    #2;
    n_chk++; if (DSP_DE !== 1'b0) begin n_fail++; $display("FAIL reset_de got %b exp 0", DSP_DE); end
    n_chk++; if ({DSP_R, DSP_G, DSP_B} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb got %h exp 000000", {DSP_R, DSP_G, DSP_B}); end
    n_chk++; if ({DSP_HSYNC_X, DSP_VSYNC_X} !== 2'b11) begin n_fail++; $display("FAIL reset_sync got %b exp 11", {DSP_HSYNC_X, DSP_VSYNC_X}); end
    n_chk++; if ({UNDERFLOW, DISP_ACT, FIFO_RD} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {UNDERFLOW, DISP_ACT, FIFO_RD}); end
    do_reset();
  endtask

  task automatic test_startup();
    for (int i = 1; i <= 200; i++) fifo_q.push_back(24'(i));
    rd_cnt = 0;
    line(1, 0, 1, -1, -1, 0, -1);
    line(1, 0, 1, -1, -1, 0, -1);
    n_chk++; if (rd_cnt != 0) begin n_fail++; $display("FAIL startup_no_rd_before_vr got %0d exp 0", rd_cnt); end
    n_chk++; if (DISP_ACT !== 1'b0) begin n_fail++; $display("FAIL startup_wait_act got %b exp 0", DISP_ACT); end
    got_first = 0; rd_cnt = 0;
    line(0, 1, 1, -1, -1, 0, -1);
    n_chk++; if (rd_cnt != 8) begin n_fail++; $display("FAIL startup_first_line_rd got %0d exp 8", rd_cnt); end
    n_chk++; if (DISP_ACT !== 1'b1) begin n_fail++; $display("FAIL startup_act got %b exp 1", DISP_ACT); end
    n_chk++; if (!got_first || first_rgb !== 24'h000001) begin n_fail++; $display("FAIL startup_first_pixel got %h exp 000001", first_rgb); end
    rd_cnt = 0;
    line(1, 0, 1, -1, -1, 0, -1);
    line(1, 0, 1, -1, -1, 0, -1);
    n_chk++; if (rd_cnt != 16) begin n_fail++; $display("FAIL startup_steady_rd got %0d exp 16", rd_cnt); end
  endtask

  task automatic test_underflow();
    rd_cnt = 0;
    line(1, 0, 1, -1, 2, 3, -1);
    n_chk++; if (rd_cnt != 5) begin n_fail++; $display("FAIL underflow_rd got %0d exp 5", rd_cnt); end
    n_chk++; if (UNDERFLOW !== 1'b1) begin n_fail++; $display("FAIL underflow_set got %b exp 1", UNDERFLOW); end
    line(1, 0, 1, -1, -1, 0, 14);
    n_chk++; if (UNDERFLOW !== 1'b0) begin n_fail++; $display("FAIL underflow_clear got %b exp 0", UNDERFLOW); end
    line(1, 0, 1, -1, 0, 1, 4);
    n_chk++; if (UNDERFLOW !== 1'b1) begin n_fail++; $display("FAIL underflow_set_wins got %b exp 1", UNDERFLOW); end
    line(1, 0, 1, -1, -1, 0, 14);
    n_chk++; if (UNDERFLOW !== 1'b0) begin n_fail++; $display("FAIL underflow_clear2 got %b exp 0", UNDERFLOW); end
  endtask

  task automatic test_dispon_drop();
    rd_cnt = 0;
    line(1, 0, 1, 8, -1, 0, -1);
    line(1, 0, 0, -1, -1, 0, -1);
    n_chk++; if (rd_cnt != 16) begin n_fail++; $display("FAIL drop_pop_continues got %0d exp 16", rd_cnt); end
    n_chk++; if (DISP_ACT !== 1'b1) begin n_fail++; $display("FAIL drop_still_act got %b exp 1", DISP_ACT); end
    rd_cnt = 0;
    line(0, 1, 0, -1, -1, 0, -1);
    line(1, 0, 0, -1, -1, 0, -1);
    n_chk++; if (rd_cnt != 0) begin n_fail++; $display("FAIL drop_no_rd_after_vr got %0d exp 0", rd_cnt); end
    n_chk++; if (DISP_ACT !== 1'b0) begin n_fail++; $display("FAIL drop_act_off got %b exp 0", DISP_ACT); end
  endtask

  task automatic test_latency();
    logic de_h[16], hs_h[16], vs_h[16];
    for (int c = 0; c < 16; c++) begin
      de_h[c] = (c >= 4 && c < 12);
      hs_h[c] = (c >= 2);
      vs_h[c] = (c >= 3);
      drive(de_h[c], hs_h[c], vs_h[c], 1'b0, 1'b0, 1'b0, 1'b0);
      if (c >= PIX_LAT) begin
        n_chk++; if (DSP_DE !== de_h[c-2]) begin n_fail++; $display("FAIL lat_de c=%0d got %b exp %b", c, DSP_DE, de_h[c-2]); end
        n_chk++; if (DSP_HSYNC_X !== hs_h[c-2]) begin n_fail++; $display("FAIL lat_hsync c=%0d got %b exp %b", c, DSP_HSYNC_X, hs_h[c-2]); end
        n_chk++; if (DSP_VSYNC_X !== vs_h[c-2]) begin n_fail++; $display("FAIL lat_vsync c=%0d got %b exp %b", c, DSP_VSYNC_X, vs_h[c-2]); end
        n_chk++; if ({DSP_R, DSP_G, DSP_B} !== (de_h[c-2] ? BLANK : 24'h0)) begin
          n_fail++; $display("FAIL lat_idle_rgb c=%0d got %h exp %h", c, {DSP_R, DSP_G, DSP_B}, de_h[c-2] ? BLANK : 24'h0);
        end
      end
    end
  endtask

  task automatic test_wait_pulse();
    rd_cnt = 0;
    line(1, 0, 1, 6, -1, 0, -1);
    line(0, 1, 0, -1, -1, 0, -1);
    n_chk++; if (DISP_ACT !== 1'b0) begin n_fail++; $display("FAIL wait_pulse_act got %b exp 0", DISP_ACT); end
    line(1, 0, 1, -1, -1, 0, -1);
    line(0, 1, 1, 0, -1, 0, -1);
    line(1, 0, 0, -1, -1, 0, -1);
    n_chk++; if (DISP_ACT !== 1'b0) begin n_fail++; $display("FAIL wait_vr_dispon_fall_act got %b exp 0", DISP_ACT); end
    n_chk++; if (rd_cnt != 0) begin n_fail++; $display("FAIL wait_pulse_rd got %0d exp 0", rd_cnt); end
  endtask

  task automatic test_reset_midline();
    logic found;
    fifo_q.delete();
    repeat (32) fifo_q.push_back(24'h123456);
    line(1, 0, 1, -1, -1, 0, -1);
    line(0, 1, 1, -1, -1, 0, -1);
    found = 0;
    for (int c = 0; c < 16; c++) begin
      drive(c >= 4 && c < 12, c >= 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (DSP_DE === 1'b1 && {DSP_R, DSP_G, DSP_B} === 24'h123456) begin
        found = 1;
        break;
      end
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL midline_pixel_seen got 0 exp 1"); end
    #1;
    sb_on = 0; DRST_X = 0;
    #1;
    n_chk++; if (DSP_DE !== 1'b0) begin n_fail++; $display("FAIL midline_reset_de got %b exp 0", DSP_DE); end
    n_chk++; if ({DSP_R, DSP_G, DSP_B} !== 24'h0) begin n_fail++; $display("FAIL midline_reset_rgb got %h exp 000000", {DSP_R, DSP_G, DSP_B}); end
    n_chk++; if ({DSP_HSYNC_X, DSP_VSYNC_X} !== 2'b11) begin n_fail++; $display("FAIL midline_reset_sync got %b exp 11", {DSP_HSYNC_X, DSP_VSYNC_X}); end
    n_chk++; if ({UNDERFLOW, FIFO_RD, DISP_ACT} !== 3'b000) begin n_fail++; $display("FAIL midline_reset_flags got %b exp 000", {UNDERFLOW, FIFO_RD, DISP_ACT}); end
    do_reset();
    line(1, 0, 0, -1, -1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_startup();
    test_underflow();
    test_dispon_drop();
    test_latency();
    test_wait_pulse();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
